// File: rtl/stream_arb_pkg.sv
// Shared types and elaboration helpers for the stream round-robin arbiter.
// The arbiter has two states: IDLE spends one cycle choosing the next
// channel and BURST forwards beats from that channel.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Ceiling log2 for sizing counters and indices; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Channel index width.  It is never narrower than one bit, so a
    // channel field always exists on the output.
    function automatic int chan_width(input int num_ch);
        int w;
        w = clog2(num_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.  The search starts at the
// channel after 'last' and wraps around.  'idx' is the first requesting
// channel found, and 'any' flags that at least one channel is requesting.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = chan_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last,
    output logic              any,
    output logic [CW-1:0]     idx
);

    localparam logic [CW:0] NUM_CH_W = (CW + 1)'(NUM_CH);

    logic [CW:0]         start;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CW-1:0]       offset;
    logic [CW:0]         sum;

    // Rotate the request vector so the preferred channel lands at bit 0.
    // Then take the lowest set bit and map that offset back to a channel.
    always_comb begin
        start = {1'b0, last} + (CW + 1)'(1);
        if (start >= NUM_CH_W) begin
            start = '0;
        end
        req_dbl = {req, req} >> start;
        req_rot = req_dbl[NUM_CH-1:0];

        any    = |req_rot;
        offset = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = CW'(k);
            end
        end

        sum = start + {1'b0, offset};
        if (sum >= NUM_CH_W) begin
            sum = sum - NUM_CH_W;
        end
        idx = sum[CW-1:0];
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that shares one downstream stream among NUM_CH
// FIFO-backed input streams.
//
// Each grant costs one IDLE arbitration cycle and then forwards up to
// BURST_LEN beats through a registered output stage.  Every output beat is
// tagged with its source channel and with a flag marking the last beat of
// the grant.
//
// Optional build macro STREAM_RR_ARBITER_PKT_EN adds a per-channel s_last_i
// input.  In that build a grant lasts until packet end or BURST_LEN, and a
// drop in valid does not release the grant.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DW        = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*DW-1:0]          s_data_i,
    input  logic [NUM_CH-1:0]             s_valid_i,
`ifdef STREAM_RR_ARBITER_PKT_EN
    input  logic [NUM_CH-1:0]             s_last_i,
`endif
    output logic [NUM_CH-1:0]             s_ready_o,
    output logic [DW-1:0]                 m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [chan_width(NUM_CH)-1:0] m_chan_o,
    output logic                          m_last_o,
    output logic                          busy_o
);

    localparam int CW = chan_width(NUM_CH);
    localparam int BW = clog2(BURST_LEN + 1);

    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);

    arb_state_t    state;
    logic [CW-1:0] grant;
    logic [CW-1:0] last_grant;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_next;

    logic          can_load;
    logic          grant_valid;
    logic          grant_pkt_last;
    logic [DW-1:0] grant_data;
    logic          accept;
    logic          burst_full;
    logic          grant_end;
    logic          idle_release;

    logic          pick_any;
    logic [CW-1:0] pick_idx;

    // The output register can take a new beat when it is empty or when
    // its current beat leaves this cycle.
    assign can_load = !m_valid_o || m_ready_i;

    assign busy_o = (state == BURST);

    // Select the data, valid and packet-end flag of the granted channel.
    always_comb begin
        grant_data     = '0;
        grant_valid    = 1'b0;
        grant_pkt_last = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant == CW'(c)) begin
                grant_data  = s_data_i[c*DW +: DW];
                grant_valid = s_valid_i[c];
`ifdef STREAM_RR_ARBITER_PKT_EN
                grant_pkt_last = s_last_i[c];
`endif
            end
        end
    end

    // Only the granted channel sees ready, and only in BURST while the
    // output register can take a beat.
    always_comb begin
        s_ready_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s_ready_o[c] = (state == BURST) && (grant == CW'(c)) && can_load;
        end
    end

    assign accept     = (state == BURST) && can_load && grant_valid;
    assign beat_next  = beat_cnt + BW'(1);
    assign burst_full = (beat_next == BURST_MAX);

`ifdef STREAM_RR_ARBITER_PKT_EN
    // A grant ends on packet end or a full burst, so packets stay whole.
    assign grant_end    = burst_full || grant_pkt_last;
    assign idle_release = 1'b0;
`else
    // A grant ends on a full burst.  It is also released when the granted
    // channel runs dry while the output could have accepted a beat.
    assign grant_end    = burst_full;
    assign idle_release = (state == BURST) && can_load && !grant_valid;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_pick (
        .req  (s_valid_i),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Grant state machine.  IDLE picks the next requester after the
    // previous owner.  BURST counts accepted beats until the grant ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_CH;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_next;
                        if (grant_end) begin
                            state      <= IDLE;
                            last_grant <= grant;
                        end
                    end else if (idle_release) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register.  It loads every accepted beat and empties when it
    // has room but nothing arrives.  It holds stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_chan_o  <= '0;
            m_last_o  <= 1'b0;
        end else if (accept) begin
            m_data_o  <= grant_data;
            m_valid_o <= 1'b1;
            m_chan_o  <= grant;
            m_last_o  <= grant_end;
        end else if (can_load) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter with NUM_CH=4, DW=32 and
// BURST_LEN=4.  Per-channel source queues model the FIFO adapters.
// Directed scenarios check fixed expected values.  A random run compares
// the DUT every cycle with a transaction-level model that tracks the owner,
// the previous owner and the beat count as plain integers.
// Set STREAM_RR_ARBITER_PKT_EN to exercise the packet build.
module tb_stream_rr_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DW        = 32;
    localparam int BURST_LEN = 4;
    localparam int CW        = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH*DW-1:0] s_data_i;
    logic [NUM_CH-1:0]    s_valid_i;
`ifdef STREAM_RR_ARBITER_PKT_EN
    logic [NUM_CH-1:0]    s_last_i;
`endif
    logic [NUM_CH-1:0]    s_ready_o;
    logic [DW-1:0]        m_data_o;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [CW-1:0]        m_chan_o;
    logic                 m_last_o;
    logic                 busy_o;

    stream_rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .DW        (DW),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
`ifdef STREAM_RR_ARBITER_PKT_EN
        .s_last_i  (s_last_i),
`endif
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_chan_o  (m_chan_o),
        .m_last_o  (m_last_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Source FIFOs feeding each channel, plus a per-channel enable that
    // creates valid gaps.
    logic [DW-1:0] src_q  [NUM_CH][$];
    bit            src_lq [NUM_CH][$];
    bit            src_en [NUM_CH];
    int            ready_pct;
    int            cyc;

    // Reference model state.
    bit            mdl_busy;
    int            mdl_owner;
    int            mdl_prev;
    int            mdl_count;
    bit            mdl_valid;
    logic [DW-1:0] mdl_data;
    int            mdl_chan;
    bit            mdl_last;

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_owner = 0;
        mdl_prev  = NUM_CH - 1;
        mdl_count = 0;
        mdl_valid = 1'b0;
        mdl_data  = '0;
        mdl_chan  = 0;
        mdl_last  = 1'b0;
    endtask

    task automatic clear_sources();
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            src_lq[c].delete();
            src_en[c] = 1'b1;
        end
    endtask

    task automatic push_beat(input int c, input logic [DW-1:0] d, input bit l);
        src_q[c].push_back(d);
        src_lq[c].push_back(l);
    endtask

    // Present the head of each enabled source queue and draw a new
    // downstream ready value.
    task automatic drive_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_en[c] && src_q[c].size() > 0) begin
                s_valid_i[c]          = 1'b1;
                s_data_i[c*DW +: DW]  = src_q[c][0];
`ifdef STREAM_RR_ARBITER_PKT_EN
                s_last_i[c]           = src_lq[c][0];
`endif
            end else begin
                s_valid_i[c]          = 1'b0;
                s_data_i[c*DW +: DW]  = '0;
`ifdef STREAM_RR_ARBITER_PKT_EN
                s_last_i[c]           = 1'b0;
`endif
            end
        end
        m_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
    endtask

    // Call this after the negedge sample.  It computes the model's next
    // state from the current inputs, crosses the clock edge, commits the
    // model, pops any accepted source beat and drives the next inputs.
    task automatic advance();
        bit            can_load;
        bit            acc;
        bit            found;
        bit            ends;
        bit            n_busy;
        bit            n_valid;
        bit            n_last;
        int            n_owner;
        int            n_prev;
        int            n_count;
        int            n_chan;
        int            c;
        logic [DW-1:0] n_data;

        can_load = !mdl_valid || m_ready_i;
        n_busy  = mdl_busy;
        n_valid = mdl_valid;
        n_last  = mdl_last;
        n_owner = mdl_owner;
        n_prev  = mdl_prev;
        n_count = mdl_count;
        n_chan  = mdl_chan;
        n_data  = mdl_data;
        acc     = 1'b0;
        found   = 1'b0;
        ends    = 1'b0;

        if (!mdl_busy) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (mdl_prev + k) % NUM_CH;
                if (!found && s_valid_i[c]) begin
                    found   = 1'b1;
                    n_owner = c;
                    n_busy  = 1'b1;
                    n_count = 0;
                end
            end
        end else if (s_valid_i[mdl_owner] && can_load) begin
            acc     = 1'b1;
            ends    = (mdl_count + 1 == BURST_LEN);
`ifdef STREAM_RR_ARBITER_PKT_EN
            ends    = ends || src_lq[mdl_owner][0];
`endif
            n_valid = 1'b1;
            n_data  = src_q[mdl_owner][0];
            n_chan  = mdl_owner;
            n_last  = ends;
            n_count = mdl_count + 1;
            if (ends) begin
                n_busy = 1'b0;
                n_prev = mdl_owner;
            end
        end else if (can_load) begin
`ifndef STREAM_RR_ARBITER_PKT_EN
            if (!s_valid_i[mdl_owner]) begin
                n_busy = 1'b0;
                n_prev = mdl_owner;
            end
`endif
        end
        if (!acc && can_load) begin
            n_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_q[mdl_owner].pop_front());
            void'(src_lq[mdl_owner].pop_front());
        end
        mdl_busy  = n_busy;
        mdl_valid = n_valid;
        mdl_last  = n_last;
        mdl_owner = n_owner;
        mdl_prev  = n_prev;
        mdl_count = n_count;
        mdl_chan  = n_chan;
        mdl_data  = n_data;
        cyc++;
        drive_inputs();
    endtask

    // Hold reset across two clock edges with empty sources and always-ready
    // downstream.  Release it one time unit after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        clear_sources();
        ready_pct = 100;
        model_reset();
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Check the reset values of every output.  After release the first
    // grant must follow last_grant = NUM_CH-1, so channel 1 wins over an
    // idle channel 0.
    task automatic test_reset();
        rst_n     = 1'b0;
        s_valid_i = '1;
        s_data_i  = '1;
        m_ready_i = 1'b1;
        @(posedge clk);
        #2;
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid_o); end
        n_cmp++; if (m_data_o !== '0) begin n_bad++; $display("[TB] FAIL reset_m_data got %h want 0", m_data_o); end
        n_cmp++; if (m_chan_o !== '0) begin n_bad++; $display("[TB] FAIL reset_m_chan got %0d want 0", m_chan_o); end
        n_cmp++; if (m_last_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_last got %b want 0", m_last_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (s_ready_o !== '0) begin n_bad++; $display("[TB] FAIL reset_s_ready got %b want 0000", s_ready_o); end

        apply_reset();
        push_beat(1, 32'h11, 1'b0);
        push_beat(3, 32'h33, 1'b0);
        drive_inputs();
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_idle_busy got %b want 0", busy_o); end
        advance();
        @(negedge clk);
        n_cmp++; if (s_ready_o !== 4'b0010) begin n_bad++; $display("[TB] FAIL reset_first_grant got %b want 0010", s_ready_o); end
        advance();
    endtask

    // A lone channel sends ten beats.  Expect m_last_o on 0xA3 and 0xA7,
    // one empty cycle between bursts, and a release once the source runs dry.
    task automatic test_lone_channel();
        int  xfer;
        int  xfer_cyc [10];
        bit  exp_last;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            push_beat(2, 32'hA0 + i, 1'b0);
        end
        drive_inputs();
        xfer = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (m_valid_o && m_ready_i) begin
                exp_last = (m_data_o == 32'hA3) || (m_data_o == 32'hA7);
                n_cmp++; if (m_chan_o !== 2'd2) begin n_bad++; $display("[TB] FAIL lone_chan got %0d want 2", m_chan_o); end
                n_cmp++; if (m_last_o !== exp_last) begin n_bad++; $display("[TB] FAIL lone_last data=%h got %b want %b", m_data_o, m_last_o, exp_last); end
                n_cmp++; if (m_data_o !== DW'(32'hA0 + xfer)) begin n_bad++; $display("[TB] FAIL lone_data got %h want %h", m_data_o, 32'hA0 + xfer); end
                if (xfer < 10) xfer_cyc[xfer] = t;
                xfer++;
            end
            advance();
        end
        n_cmp++; if (xfer !== 10) begin n_bad++; $display("[TB] FAIL lone_count got %0d want 10", xfer); end
        if (xfer >= 10) begin
            for (int i = 1; i < 10; i++) begin
                n_cmp++;
                if (xfer_cyc[i] - xfer_cyc[i-1] !== ((i % 4 == 0) ? 2 : 1)) begin
                    n_bad++;
                    $display("[TB] FAIL lone_gap beat %0d got %0d want %0d", i, xfer_cyc[i] - xfer_cyc[i-1], (i % 4 == 0) ? 2 : 1);
                end
            end
        end
`ifndef STREAM_RR_ARBITER_PKT_EN
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL lone_release got busy %b want 0", busy_o); end
`endif
    endtask

    // Four channels request continuously.  Expect grants in the order
    // 0,1,2,3,0, each exactly BURST_LEN beats, with per-channel data in order.
    task automatic test_all_channels();
        int            nb;
        int            run_len;
        int            burst_ch  [6];
        int            burst_len [6];
        int            next_idx  [NUM_CH];
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            next_idx[c] = 0;
            for (int i = 0; i < 12; i++) begin
                push_beat(c, DW'(256 * c + i), 1'b0);
            end
        end
        drive_inputs();
        nb      = 0;
        run_len = 0;
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            if (m_valid_o && m_ready_i) begin
                exp_d = DW'(256 * int'(m_chan_o) + next_idx[m_chan_o]);
                n_cmp++; if (m_data_o !== exp_d) begin n_bad++; $display("[TB] FAIL all_data got %h want %h", m_data_o, exp_d); end
                next_idx[m_chan_o]++;
                run_len++;
                if (m_last_o) begin
                    if (nb < 6) begin
                        burst_ch[nb]  = int'(m_chan_o);
                        burst_len[nb] = run_len;
                    end
                    nb++;
                    run_len = 0;
                end
            end
            advance();
        end
        n_cmp++; if (nb < 5) begin n_bad++; $display("[TB] FAIL all_bursts got %0d want at least 5", nb); end
        if (nb >= 5) begin
            for (int b = 0; b < 5; b++) begin
                n_cmp++; if (burst_ch[b] !== b % 4) begin n_bad++; $display("[TB] FAIL all_order burst %0d got %0d want %0d", b, burst_ch[b], b % 4); end
                n_cmp++; if (burst_len[b] !== BURST_LEN) begin n_bad++; $display("[TB] FAIL all_len burst %0d got %0d want %0d", b, burst_len[b], BURST_LEN); end
            end
        end
    endtask

    // Channel 1 bursts while downstream ready goes 1,0,0,1.  The held beat
    // must stay stable, ready to the channel must drop, and no beat may be
    // lost or duplicated.
    task automatic test_stall();
        logic [DW-1:0] got [$];
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            push_beat(1, 32'hB0 + i, 1'b0);
        end
        drive_inputs();
        for (int t = 0; t < 20; t++) begin
            m_ready_i = (t == 2 || t == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (t >= 2 && t <= 4) begin
                n_cmp++; if (m_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_valid t=%0d got %b want 1", t, m_valid_o); end
                n_cmp++; if (m_data_o !== 32'hB0) begin n_bad++; $display("[TB] FAIL stall_data t=%0d got %h want b0", t, m_data_o); end
                n_cmp++; if (m_chan_o !== 2'd1) begin n_bad++; $display("[TB] FAIL stall_chan t=%0d got %0d want 1", t, m_chan_o); end
                n_cmp++; if (m_last_o !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_last t=%0d got %b want 0", t, m_last_o); end
            end
            if (t == 2 || t == 3) begin
                n_cmp++; if (s_ready_o[1] !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_ready t=%0d got %b want 0", t, s_ready_o[1]); end
            end
            if (m_valid_o && m_ready_i) got.push_back(m_data_o);
            advance();
        end
        n_cmp++; if (got.size() !== 6) begin n_bad++; $display("[TB] FAIL stall_count got %0d want 6", got.size()); end
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (got[i] !== DW'(32'hB0 + i)) begin n_bad++; $display("[TB] FAIL stall_order idx %0d got %h want %h", i, got[i], 32'hB0 + i); end
            end
        end
    endtask

`ifndef STREAM_RR_ARBITER_PKT_EN
    // Channel 0 sends two beats and then goes quiet.  The grant must be
    // released, busy must drop for one cycle, and channel 3 must be next.
    task automatic test_idle_release();
        bit   exp_busy [6];
        logic [NUM_CH-1:0] exp_rdy [6];
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_rdy  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000};
        apply_reset();
        push_beat(0, 32'hC0, 1'b0);
        push_beat(0, 32'hC1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_beat(3, 32'hD0 + i, 1'b0);
        end
        drive_inputs();
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            n_cmp++; if (busy_o !== exp_busy[t]) begin n_bad++; $display("[TB] FAIL release_busy t=%0d got %b want %b", t, busy_o, exp_busy[t]); end
            n_cmp++; if (s_ready_o !== exp_rdy[t]) begin n_bad++; $display("[TB] FAIL release_ready t=%0d got %b want %b", t, s_ready_o, exp_rdy[t]); end
            advance();
        end
    endtask
`endif

    // Assert reset after two beats of a burst.  The outputs must clear at
    // once, and the first grant after release must go to channel 0.
    task automatic test_reset_mid_burst();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            push_beat(1, 32'hE0 + i, 1'b0);
        end
        drive_inputs();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            advance();
        end
        n_cmp++; if (m_valid_o !== 1'b1 || busy_o !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_pre got valid %b busy %b want 1 1", m_valid_o, busy_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_valid got %b want 0", m_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy got %b want 0", busy_o); end
        n_cmp++; if (s_ready_o !== '0) begin n_bad++; $display("[TB] FAIL midrst_ready got %b want 0000", s_ready_o); end
        n_cmp++; if (m_data_o !== '0) begin n_bad++; $display("[TB] FAIL midrst_data got %h want 0", m_data_o); end
        clear_sources();
        model_reset();
        push_beat(0, 32'hF0, 1'b0);
        push_beat(0, 32'hF1, 1'b0);
        push_beat(2, 32'hF2, 1'b0);
        drive_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_idle got busy %b want 0", busy_o); end
        advance();
        @(negedge clk);
        n_cmp++; if (s_ready_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL midrst_grant got %b want 0001", s_ready_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_burst got busy %b want 1", busy_o); end
        advance();
    endtask

`ifdef STREAM_RR_ARBITER_PKT_EN
    // Channel 1 sends a 3-beat packet with a valid gap while channel 2
    // waits.  The grant must survive the gap, m_last_o must mark beat 3,
    // and channel 2 must follow.
    task automatic test_packet();
        logic [DW-1:0] got_d [$];
        int            got_c [$];
        bit            got_l [$];
        logic [DW-1:0] exp_d [5];
        int            exp_c [5];
        bit            exp_l [5];
        exp_d = '{32'h50, 32'h51, 32'h52, 32'h60, 32'h61};
        exp_c = '{1, 1, 1, 2, 2};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        push_beat(1, 32'h50, 1'b0);
        push_beat(1, 32'h51, 1'b0);
        push_beat(1, 32'h52, 1'b1);
        push_beat(2, 32'h60, 1'b0);
        push_beat(2, 32'h61, 1'b1);
        for (int t = 0; t < 15; t++) begin
            src_en[1] = (t != 2);
            drive_inputs();
            @(negedge clk);
            if (t == 2) begin
                n_cmp++; if (busy_o !== 1'b1 || s_ready_o !== 4'b0010) begin n_bad++; $display("[TB] FAIL pkt_hold got busy %b ready %b want 1 0010", busy_o, s_ready_o); end
            end
            if (m_valid_o && m_ready_i) begin
                got_d.push_back(m_data_o);
                got_c.push_back(int'(m_chan_o));
                got_l.push_back(m_last_o);
            end
            advance();
        end
        n_cmp++; if (got_d.size() !== 5) begin n_bad++; $display("[TB] FAIL pkt_count got %0d want 5", got_d.size()); end
        if (got_d.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_l[i] !== exp_l[i]) begin
                    n_bad++;
                    $display("[TB] FAIL pkt_beat %0d got %h/%0d/%b want %h/%0d/%b", i, got_d[i], got_c[i], got_l[i], exp_d[i], exp_c[i], exp_l[i]);
                end
            end
        end
    endtask
`endif

    // Random sources, valid gaps and downstream back-pressure.  Every
    // cycle the DUT is compared against the reference model.
    task automatic test_random();
        logic [NUM_CH-1:0] exp_rdy;
        apply_reset();
        ready_pct = 70;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
                push_beat(c, $urandom, ($urandom_range(0, 99) < 30));
            end
        end
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                src_en[c] = ($urandom_range(0, 99) < 80);
                if ($urandom_range(0, 99) < 15) begin
                    push_beat(c, $urandom, ($urandom_range(0, 99) < 30));
                end
            end
            drive_inputs();
            @(negedge clk);
            exp_rdy = '0;
            if (mdl_busy && (!mdl_valid || m_ready_i)) exp_rdy = NUM_CH'(1) << mdl_owner;
            n_cmp++; if (s_ready_o !== exp_rdy) begin n_bad++; $display("[TB] FAIL rand_ready t=%0d got %b want %b", t, s_ready_o, exp_rdy); end
            n_cmp++; if (busy_o !== mdl_busy) begin n_bad++; $display("[TB] FAIL rand_busy t=%0d got %b want %b", t, busy_o, mdl_busy); end
            n_cmp++; if (m_valid_o !== mdl_valid) begin n_bad++; $display("[TB] FAIL rand_valid t=%0d got %b want %b", t, m_valid_o, mdl_valid); end
            n_cmp++; if (m_data_o !== mdl_data) begin n_bad++; $display("[TB] FAIL rand_data t=%0d got %h want %h", t, m_data_o, mdl_data); end
            n_cmp++; if (m_chan_o !== CW'(mdl_chan)) begin n_bad++; $display("[TB] FAIL rand_chan t=%0d got %0d want %0d", t, m_chan_o, mdl_chan); end
            n_cmp++; if (m_last_o !== mdl_last) begin n_bad++; $display("[TB] FAIL rand_last t=%0d got %b want %b", t, m_last_o, mdl_last); end
            advance();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid_i = '0;
        s_data_i  = '0;
`ifdef STREAM_RR_ARBITER_PKT_EN
        s_last_i  = '0;
`endif
        m_ready_i = 1'b0;
        ready_pct = 100;
        cyc       = 0;
        model_reset();

        test_reset();
        test_lone_channel();
        test_all_channels();
        test_stall();
`ifndef STREAM_RR_ARBITER_PKT_EN
        test_idle_release();
`endif
        test_reset_mid_burst();
`ifdef STREAM_RR_ARBITER_PKT_EN
        test_packet();
`endif
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
